// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin arbiter that time-shares one combinational
// multiplier among NREQ requesters, each with valid/ready request and response.
//
// state   | meaning
// IDLE    | no operation in flight; grant is combinational from req_valid
// COMPUTE | captured operands drive the multiplier; product sampled this cycle
// RESPOND | product held on rsp_product until the owning requester accepts it
module mul_share_ctrl #(
  parameter int NREQ = 2,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [2*W-1:0]    rsp_product,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_product,
  output logic              busy,
  output logic [7:0]        op_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   ptr_nxt;
  logic            grant_any;
  logic [NREQ-1:0] grant_oh;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [2*W-1:0]  res;
  logic            accept;
  logic            done;

  // Search order is ptr, ptr+1, ... so the first hit in k wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && req_valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          grant_any = 1'b1;
          grant_idx = IW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = grant_any && (int'(grant_idx) == i);
      if (int'(grant_idx) == i) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  assign ptr_nxt = (int'(owner) == NREQ - 1) ? '0 : owner + IW'(1);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COMPUTE;
      COMPUTE: state_nxt = RESPOND;
      RESPOND: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state == IDLE) && grant_oh[i];
      rsp_valid[i] = (state == RESPOND) && (int'(owner) == i);
    end
    accept = |(req_valid & req_ready);
    done   = |(rsp_valid & rsp_ready);
    busy   = (state != IDLE);
  end

  // Datapath registers; operands are only sampled on the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      owner    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      op_count <= '0;
    end else begin
      if (state == IDLE && accept) begin
        op_a  <= sel_a;
        op_b  <= sel_b;
        owner <= grant_idx;
      end
      if (state == COMPUTE) begin
        res <= mul_product;
      end
      if (state == RESPOND && done) begin
        ptr      <= ptr_nxt;
        op_count <= op_count + 8'd1;
      end
    end
  end

  assign mul_a       = op_a;
  assign mul_b       = op_b;
  assign rsp_product = res;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with NREQ=2, W=4; the external multiplier
// is modelled here as a plain unsigned product of mul_a and mul_b.
module tb_mul_share_ctrl;
  localparam int NREQ = 2;
  localparam int W    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [2*W-1:0]    rsp_product;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_product;
  logic              busy;
  logic [7:0]        op_count;

  int checks = 0;
  int failures = 0;

  mul_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .busy(busy), .op_count(op_count)
  );

  assign mul_product = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0;
    rsp_ready = '0;
    req_a = '0;
    req_b = '0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Drives one full transaction; returns the observed product, no checking.
  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] prod, output bit ok);
    bit got;
    got = 1'b0;
    ok = 1'b0;
    prod = '0;
    req_valid = '0;
    rsp_ready = '0;
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (req_ready[i]) got = 1'b1;
      tick;
    end
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    if (got) begin
      for (int c = 0; c < 8 && !ok; c++) begin
        if (rsp_valid[i]) begin
          ok = 1'b1;
          prod = rsp_product;
        end
        tick;
      end
    end
    rsp_ready[i] = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_product !== 8'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", rsp_product); end
    checks++; if ({mul_a, mul_b} !== 8'd0) begin failures++; $display("FAIL reset_mul got=%0d,%0d exp=0,0", mul_a, mul_b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
  endtask

  task automatic test_single;
    do_reset;
    req_valid = 2'b01;
    req_a[3:0] = 4'd3;
    req_b[3:0] = 4'd5;
    rsp_ready = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_grant got=%b exp=01", req_ready); end
    tick;
    req_valid = 2'b00;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_early_rsp got=%b exp=00", rsp_valid); end
    checks++; if ({mul_a, mul_b} !== {4'd3, 4'd5}) begin failures++; $display("FAIL single_mul_ops got=%0d,%0d exp=3,5", mul_a, mul_b); end
    tick;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_product !== 8'd15) begin failures++; $display("FAIL single_product got=%0d exp=15", rsp_product); end
    tick;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin failures++; $display("FAIL single_done got busy=%b rsp=%b exp busy=0 rsp=00", busy, rsp_valid); end
    checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
    checks++; if (rsp_product !== 8'd15) begin failures++; $display("FAIL single_hold got=%0d exp=15", rsp_product); end
    rsp_ready = 2'b00;
  endtask

  task automatic test_extremes;
    logic [2*W-1:0] p;
    bit ok;
    run_op(0, 4'd15, 4'd15, p, ok);
    checks++; if (!ok || p !== 8'd225) begin failures++; $display("FAIL ext_15x15 got=%0d ok=%b exp=225", p, ok); end
    run_op(1, 4'd0, 4'd9, p, ok);
    checks++; if (!ok || p !== 8'd0) begin failures++; $display("FAIL ext_0x9 got=%0d ok=%b exp=0", p, ok); end
    run_op(0, 4'd1, 4'd15, p, ok);
    checks++; if (!ok || p !== 8'd15) begin failures++; $display("FAIL ext_1x15 got=%0d ok=%b exp=15", p, ok); end
    checks++; if (op_count !== 8'd4) begin failures++; $display("FAIL ext_op_count got=%0d exp=4", op_count); end
  endtask

  task automatic test_contention;
    do_reset;
    req_a = {4'd4, 4'd2};
    req_b = {4'd4, 4'd7};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL cont_first got=%b exp=01", req_ready); end
    tick;
    tick;
    checks++; if (rsp_valid !== 2'b01 || rsp_product !== 8'd14) begin failures++; $display("FAIL cont_rsp0 got rsp=%b p=%0d exp rsp=01 p=14", rsp_valid, rsp_product); end
    tick;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL cont_second got=%b exp=10", req_ready); end
    tick;
    req_valid = 2'b01;
    tick;
    checks++; if (rsp_valid !== 2'b10 || rsp_product !== 8'd16) begin failures++; $display("FAIL cont_rsp1 got rsp=%b p=%0d exp rsp=10 p=16", rsp_valid, rsp_product); end
    tick;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL cont_wrap got=%b exp=01", req_ready); end
    tick;
    req_valid = 2'b00;
    tick;
    tick;
    checks++; if (op_count !== 8'd3 || busy !== 1'b0) begin failures++; $display("FAIL cont_count got=%0d busy=%b exp=3 busy=0", op_count, busy); end
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure;
    do_reset;
    req_a = {4'd5, 4'd6};
    req_b = {4'd5, 4'd3};
    req_valid = 2'b01;
    #1;
    tick;
    req_valid = 2'b10;
    tick;
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 2'b01 || rsp_product !== 8'd18) begin failures++; $display("FAIL bp_hold[%0d] got rsp=%b p=%0d exp rsp=01 p=18", c, rsp_valid, rsp_product); end
      checks++; if (req_ready !== 2'b00 || busy !== 1'b1) begin failures++; $display("FAIL bp_block[%0d] got rdy=%b busy=%b exp rdy=00 busy=1", c, req_ready, busy); end
      tick;
    end
    rsp_ready = 2'b01;
    #1;
    tick;
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_release got busy=%b rsp=%b exp busy=0 rsp=00", busy, rsp_valid); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    rsp_ready = 2'b10;
    tick;
    req_valid = 2'b00;
    tick;
    checks++; if (rsp_valid !== 2'b10 || rsp_product !== 8'd25) begin failures++; $display("FAIL bp_rsp1 got rsp=%b p=%0d exp rsp=10 p=25", rsp_valid, rsp_product); end
    tick;
    rsp_ready = 2'b00;
  endtask

  task automatic test_operand_change;
    do_reset;
    req_a[3:0] = 4'd7;
    req_b[3:0] = 4'd6;
    req_valid = 2'b01;
    #1;
    tick;
    req_a[3:0] = 4'd1;
    req_b[3:0] = 4'd1;
    req_valid = 2'b00;
    tick;
    checks++; if (rsp_product !== 8'd42) begin failures++; $display("FAIL opchg_product got=%0d exp=42", rsp_product); end
    rsp_ready = 2'b10;
    tick;
    checks++; if (rsp_valid !== 2'b01 || op_count !== 8'd0) begin failures++; $display("FAIL opchg_nonowner got rsp=%b cnt=%0d exp rsp=01 cnt=0", rsp_valid, op_count); end
    rsp_ready = 2'b00;
    tick;
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL opchg_still got=%b exp=01", rsp_valid); end
    rsp_ready = 2'b01;
    tick;
    checks++; if (op_count !== 8'd1 || busy !== 1'b0) begin failures++; $display("FAIL opchg_done got cnt=%0d busy=%b exp cnt=1 busy=0", op_count, busy); end
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid;
    logic [2*W-1:0] p;
    bit ok;
    do_reset;
    run_op(0, 4'd2, 4'd2, p, ok);
    req_a[7:4] = 4'd3;
    req_b[7:4] = 4'd3;
    req_valid = 2'b10;
    #1;
    tick;
    req_valid = 2'b00;
    tick;
    checks++; if (rsp_valid !== 2'b10 || op_count !== 8'd1) begin failures++; $display("FAIL mid_setup got rsp=%b cnt=%0d exp rsp=10 cnt=1", rsp_valid, op_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00 || op_count !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_async got rsp=%b cnt=%0d busy=%b exp 00/0/0", rsp_valid, op_count, busy); end
    #1;
    rst_n = 1'b1;
    tick;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL mid_ptr got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    run_op(0, 4'd2, 4'd3, p, ok);
    checks++; if (!ok || p !== 8'd6 || op_count !== 8'd1) begin failures++; $display("FAIL mid_recover got p=%0d ok=%b cnt=%0d exp p=6 cnt=1", p, ok, op_count); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_extremes;
    test_contention;
    test_backpressure;
    test_operand_change;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
